// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: region encoding, 640x480@60 defaults and
// total-period helpers reused by the sync generator and colour generator.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FRONT,
    REG_SYNC,
    REG_BACK
  } region_e;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return active + front + sync + back;
  endfunction

  function automatic int unsigned h_total();
    return axis_total(VGA_H_ACTIVE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
  endfunction

  function automatic int unsigned v_total();
    return axis_total(VGA_V_ACTIVE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK
// region tracker, both advancing only when step_i is high.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FRONT  = VGA_H_FRONT,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BACK   = VGA_H_BACK
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             step_i,
  output logic [CNT_W-1:0] count_o,
  output region_e          region_next_o,
  output logic             wrap_o
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

  localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(ACTIVE + FRONT - 1);
  localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [CNT_W-1:0] END_TOTAL  = CNT_W'(TOTAL - 1);

  if (TOTAL > 1023) begin : g_total_check
    $fatal(1, "vga_axis_counter: timing total exceeds 10-bit counter range");
  end

  logic [CNT_W-1:0] count_q, count_d;
  region_e          region_q, region_d;
  logic             wrap;

  always_comb begin
    count_d  = count_q;
    region_d = region_q;
    wrap     = 1'b0;
    if (step_i) begin
      if (count_q == END_TOTAL) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
      case (region_q)
        REG_ACTIVE: if (count_q == END_ACTIVE) region_d = REG_FRONT;
        REG_FRONT:  if (count_q == END_FRONT)  region_d = REG_SYNC;
        REG_SYNC:   if (count_q == END_SYNC)   region_d = REG_BACK;
        REG_BACK:   if (count_q == END_TOTAL)  region_d = REG_ACTIVE;
        default:                               region_d = REG_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q  <= '0;
      region_q <= REG_ACTIVE;
    end else begin
      count_q  <= count_d;
      region_q <= region_d;
    end
  end

  assign count_o       = count_q;
  assign region_next_o = region_d;
  assign wrap_o        = wrap;

endmodule

// File: rtl/vga_sync_640x480.sv
// VGA sync generator: H and V axis counters advanced by the pixel tick, with
// sync/blank/frame-start outputs registered in step with the counters.
module vga_sync_640x480
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT  = VGA_H_FRONT,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BACK   = VGA_H_BACK,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT  = VGA_V_FRONT,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BACK   = VGA_V_BACK,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start
);

  logic [CNT_W-1:0] h_count, v_count;
  region_e          h_region_d, v_region_d;
  logic             h_wrap, v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_axis (
    .clk           (clk),
    .clr_n         (clr_n),
    .step_i        (pix_en),
    .count_o       (h_count),
    .region_next_o (h_region_d),
    .wrap_o        (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_axis (
    .clk           (clk),
    .clr_n         (clr_n),
    .step_i        (h_wrap & pix_en),
    .count_o       (v_count),
    .region_next_o (v_region_d),
    .wrap_o        (v_wrap)
  );

  logic hsync_q, vsync_q, video_on_q, frame_start_q;

  // Decoded from next-state regions so outputs line up with the counters.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= (h_region_d == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= (v_region_d == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on_q    <= (h_region_d == REG_ACTIVE) && (v_region_d == REG_ACTIVE);
      frame_start_q <= h_wrap & v_wrap;
    end
  end

  assign hcount      = h_count;
  assign vcount      = v_count;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_640x480.sv
// Directed bench: default 640x480 timing at a 1-in-4 pixel tick, plus a
// shrunken-timing instance (positive sync) run at full rate for frame-level behaviour.
module tb_vga_sync_640x480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       d_clr_n, d_pix_en;
  logic [9:0] d_hcount, d_vcount;
  logic       d_hsync, d_vsync, d_video_on, d_frame_start;

  logic       s_clr_n, s_pix_en;
  logic [9:0] s_hcount, s_vcount;
  logic       s_hsync, s_vsync, s_video_on, s_frame_start;

  vga_sync_640x480 u_dut (
    .clk         (clk),
    .clr_n       (d_clr_n),
    .pix_en      (d_pix_en),
    .hcount      (d_hcount),
    .vcount      (d_vcount),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .video_on    (d_video_on),
    .frame_start (d_frame_start)
  );

  // H: 6/2/3/2 = 13, V: 4/1/2/2 = 9, frame = 117 ticks, sync active-high.
  vga_sync_640x480 #(
    .H_ACTIVE (6), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
    .SYNC_POL (1'b1)
  ) u_small (
    .clk         (clk),
    .clr_n       (s_clr_n),
    .pix_en      (s_pix_en),
    .hcount      (s_hcount),
    .vcount      (s_vcount),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .video_on    (s_video_on),
    .frame_start (s_frame_start)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic d_fs_edge;
  int   d_edge_cyc;

  // One pixel tick every 4 clocks; frame_start is captured right after the enabled edge.
  task automatic d_tick();
    d_pix_en = 1'b1;
    step();
    d_fs_edge  = d_frame_start;
    d_edge_cyc = cyc;
    d_pix_en   = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_low, lows, max_h, wrap_cyc;
    int exp_h, exp_v, fs_count, fs_last, fs_gap, vs_frame;
    logic exp_fs;

    d_clr_n = 1'b0; d_pix_en = 1'b0;
    s_clr_n = 1'b0; s_pix_en = 1'b0;

    // Reset hold with pix_en toggling
    for (int i = 0; i < 5; i++) begin
      d_pix_en = i[0];
      s_pix_en = i[0];
      step();
      chk("rst_hcount", d_hcount, 0);
      chk("rst_vcount", d_vcount, 0);
      chk("rst_hsync", d_hsync, 1);
      chk("rst_vsync", d_vsync, 1);
      chk("rst_video_on", d_video_on, 1);
      chk("rst_frame_start", d_frame_start, 0);
      chk("rst_s_hsync", s_hsync, 0);
      chk("rst_s_vsync", s_vsync, 0);
    end
    d_pix_en = 1'b0; s_pix_en = 1'b0;
    d_clr_n = 1'b1; s_clr_n = 1'b1;
    step();
    chk("release_hold", d_hcount, 0);

    d_tick();
    chk("first_tick_h", d_hcount, 1);
    chk("first_tick_v", d_vcount, 0);
    chk("first_tick_no_fs", d_fs_edge, 0);

    repeat (299) d_tick();
    chk("at300_h", d_hcount, 300);
    chk("at300_video", d_video_on, 1);
    chk("at300_hsync", d_hsync, 1);

    for (int i = 0; i < 50; i++) begin
      step();
      chk("stall_h", d_hcount, 300);
      chk("stall_v", d_vcount, 0);
      chk("stall_hsync", d_hsync, 1);
      chk("stall_video", d_video_on, 1);
      chk("stall_fs", d_frame_start, 0);
    end
    d_tick();
    chk("resume_h", d_hcount, 301);

    repeat (338) d_tick();
    chk("at639_h", d_hcount, 639);
    chk("at639_video", d_video_on, 1);
    d_tick();
    chk("at640_h", d_hcount, 640);
    chk("at640_video", d_video_on, 0);

    first_low = -1;
    lows = 0;
    for (int i = 0; i < 200 && d_hcount != 10'd0; i++) begin
      d_tick();
      if (d_hsync == 1'b0) begin
        lows++;
        if (first_low < 0) first_low = int'(d_hcount);
      end
    end
    chk("hsync_ticks", lows, 96);
    chk("hsync_start", first_low, 656);
    chk("wrap1_h", d_hcount, 0);
    chk("wrap1_v", d_vcount, 1);
    chk("wrap1_no_fs", d_fs_edge, 0);
    chk("line1_video", d_video_on, 1);
    chk("line1_hsync", d_hsync, 1);
    wrap_cyc = d_edge_cyc;

    max_h = 0;
    for (int i = 0; i < 1000; i++) begin
      d_tick();
      if (int'(d_hcount) > max_h) max_h = int'(d_hcount);
      if (d_hcount == 10'd0) break;
    end
    chk("line_max_h", max_h, 799);
    chk("line_clks", d_edge_cyc - wrap_cyc, 3200);
    chk("wrap2_v", d_vcount, 2);

    repeat (700) d_tick();
    chk("at700_h", d_hcount, 700);
    chk("at700_hsync", d_hsync, 0);
    chk("at700_video", d_video_on, 0);

    // Asynchronous reset between clock edges
    #2 d_clr_n = 1'b0;
    #1;
    chk("arst_h", d_hcount, 0);
    chk("arst_v", d_vcount, 0);
    chk("arst_hsync", d_hsync, 1);
    chk("arst_vsync", d_vsync, 1);
    chk("arst_video", d_video_on, 1);
    chk("arst_fs", d_frame_start, 0);
    step();
    d_clr_n = 1'b1;
    step();
    chk("arst_release_h", d_hcount, 0);
    d_tick();
    chk("arst_tick_h", d_hcount, 1);
    chk("arst_tick_v", d_vcount, 0);
    chk("arst_tick_fs", d_fs_edge, 0);

    // Small instance at full rate: 307 ticks ends at (8,5), inside both sync regions
    exp_h = 0; exp_v = 0;
    fs_count = 0; fs_last = 0; fs_gap = 0; vs_frame = 0;
    s_pix_en = 1'b1;
    for (int i = 1; i <= 307; i++) begin
      step();
      exp_fs = 1'b0;
      if (exp_h == 12) begin
        exp_h = 0;
        if (exp_v == 8) begin
          exp_v  = 0;
          exp_fs = 1'b1;
        end else begin
          exp_v++;
        end
      end else begin
        exp_h++;
      end
      chk("s_hcount", s_hcount, exp_h);
      chk("s_vcount", s_vcount, exp_v);
      chk("s_hsync", s_hsync, (exp_h >= 8 && exp_h <= 10) ? 1 : 0);
      chk("s_vsync", s_vsync, (exp_v >= 5 && exp_v <= 6) ? 1 : 0);
      chk("s_video_on", s_video_on, (exp_h < 6 && exp_v < 4) ? 1 : 0);
      chk("s_frame_start", s_frame_start, exp_fs);
      if (s_frame_start) begin
        fs_count++;
        if (fs_last != 0) fs_gap = i - fs_last;
        fs_last = i;
      end
      if (i <= 117 && s_vsync) vs_frame++;
    end
    chk("s_fs_count", fs_count, 2);
    chk("s_fs_gap", fs_gap, 117);
    chk("s_vsync_ticks", vs_frame, 26);

    s_pix_en = 1'b0;
    #2 s_clr_n = 1'b0;
    #1;
    chk("s_arst_h", s_hcount, 0);
    chk("s_arst_v", s_vcount, 0);
    chk("s_arst_hsync", s_hsync, 0);
    chk("s_arst_vsync", s_vsync, 0);
    chk("s_arst_video", s_video_on, 1);
    step();
    s_clr_n = 1'b1;
    s_pix_en = 1'b1;
    step();
    chk("s_restart_h", s_hcount, 1);
    chk("s_restart_v", s_vcount, 0);
    chk("s_restart_vsync", s_vsync, 0);
    chk("s_restart_fs", s_frame_start, 0);
    s_pix_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
